// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter: step/load controls in, stage outputs and flags back.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, count_n, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, count_n, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK stages with load clamp, terminal count and wrap pulse.
// Build option: define JK_MOD_COUNTER_SAT_EN to hold at the terminal instead of wrapping around.
module jk_mod_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic            clk,
    input  logic            reset,
    jk_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] TERM_MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_top;
    logic             at_bot;
    logic             step_wrap;
    logic             wrap_q;

    always_comb begin
        at_top    = (q == TERM_MAX);
        at_bot    = (q == '0);
        nx        = q;
        step_wrap = 1'b0;
        if (bus.load) begin
            // Load values at or above the modulus would escape the legal range.
            nx = ({1'b0, bus.load_val} >= MOD_EXT) ? TERM_MAX : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_top) begin
                    step_wrap = 1'b1;
`ifdef JK_MOD_COUNTER_SAT_EN
                    nx = q;
`else
                    nx = '0;
`endif
                end else begin
                    nx = q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    step_wrap = 1'b1;
`ifdef JK_MOD_COUNTER_SAT_EN
                    nx = q;
`else
                    nx = TERM_MAX;
`endif
                end else begin
                    nx = q - WIDTH'(1);
                end
            end
        end
        j = nx & ~q;
        k = ~nx & q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q[i] <= 1'b0;
            end else begin
                case ({j[i], k[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step_wrap;
        end
    end

    assign bus.count   = q;
    assign bus.count_n = ~q;
    assign bus.tc      = bus.up ? at_top : at_bot;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a WIDTH=4/MODULO=10 instance and a WIDTH=2/MODULO=2 instance.
module tb_jk_mod_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    jk_mod_counter_if #(.WIDTH(4)) bus1 ();
    jk_mod_counter_if #(.WIDTH(2)) bus2 ();

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    jk_mod_counter #(.WIDTH(2), .MODULO(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus1.en = 0; bus1.up = 1; bus1.load = 0; bus1.load_val = '0;
        bus2.en = 0; bus2.up = 1; bus2.load = 0; bus2.load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus1.count !== 4'h0) begin miscompares++; $display("FAIL reset_count: got %0h expected 0", bus1.count); end
        vectors++;
        if (bus1.count_n !== 4'hF) begin miscompares++; $display("FAIL reset_count_n: got %0h expected f", bus1.count_n); end
        vectors++;
        if (bus1.wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b expected 0", bus1.wrap); end
        vectors++;
        if (bus1.tc !== 1'b0) begin miscompares++; $display("FAIL reset_tc_up: got %b expected 0", bus1.tc); end
        bus1.up = 0;
        #1;
        vectors++;
        if (bus1.tc !== 1'b1) begin miscompares++; $display("FAIL reset_tc_down: got %b expected 1", bus1.tc); end
        vectors++;
        if (bus2.count !== 2'h0) begin miscompares++; $display("FAIL reset_count2: got %0h expected 0", bus2.count); end
        bus1.up = 1;
        #1 reset = 1'b1;
    endtask

`ifndef JK_MOD_COUNTER_SAT_EN
    task automatic test_up_count();
        logic [3:0] exp_c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        bus1.en = 1; bus1.up = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (bus1.count !== exp_c[i]) begin miscompares++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, bus1.count, exp_c[i]); end
            vectors++;
            if (bus1.count_n !== ~exp_c[i]) begin miscompares++; $display("FAIL up_count_n[%0d]: got %0h expected %0h", i, bus1.count_n, ~exp_c[i]); end
            vectors++;
            if (bus1.tc !== (exp_c[i] == 4'd9)) begin miscompares++; $display("FAIL up_tc[%0d]: got %b expected %b", i, bus1.tc, exp_c[i] == 4'd9); end
            vectors++;
            if (bus1.wrap !== (i == 9)) begin miscompares++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, bus1.wrap, i == 9); end
        end
        bus1.en = 0;
    endtask
`else
    task automatic test_saturate();
        bus1.en = 1; bus1.up = 1;
        repeat (9) tick();
        vectors++;
        if (bus1.count !== 4'd9) begin miscompares++; $display("FAIL sat_reach: got %0d expected 9", bus1.count); end
        vectors++;
        if (bus1.wrap !== 1'b0) begin miscompares++; $display("FAIL sat_reach_wrap: got %b expected 0", bus1.wrap); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus1.count !== 4'd9) begin miscompares++; $display("FAIL sat_hold[%0d]: got %0d expected 9", i, bus1.count); end
            vectors++;
            if (bus1.wrap !== 1'b1) begin miscompares++; $display("FAIL sat_wrap[%0d]: got %b expected 1", i, bus1.wrap); end
        end
        bus1.en = 0;
    endtask
`endif

    task automatic test_down_count();
`ifndef JK_MOD_COUNTER_SAT_EN
        logic [3:0] exp_c [3] = '{4'd9, 4'd8, 4'd7};
        logic       exp_w [3] = '{1'b1, 1'b0, 1'b0};
        logic       exp_t [3] = '{1'b0, 1'b0, 1'b0};
`else
        logic [3:0] exp_c [3] = '{4'd0, 4'd0, 4'd0};
        logic       exp_w [3] = '{1'b1, 1'b1, 1'b1};
        logic       exp_t [3] = '{1'b1, 1'b1, 1'b1};
`endif
        bus1.load = 1; bus1.load_val = 4'd0; bus1.en = 1;
        tick();
        vectors++;
        if (bus1.count !== 4'd0) begin miscompares++; $display("FAIL down_load0: got %0d expected 0", bus1.count); end
        bus1.load = 0; bus1.up = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus1.count !== exp_c[i]) begin miscompares++; $display("FAIL down_count[%0d]: got %0d expected %0d", i, bus1.count, exp_c[i]); end
            vectors++;
            if (bus1.wrap !== exp_w[i]) begin miscompares++; $display("FAIL down_wrap[%0d]: got %b expected %b", i, bus1.wrap, exp_w[i]); end
            vectors++;
            if (bus1.tc !== exp_t[i]) begin miscompares++; $display("FAIL down_tc[%0d]: got %b expected %b", i, bus1.tc, exp_t[i]); end
        end
        bus1.en = 0; bus1.up = 1;
    endtask

    task automatic test_load();
        logic [3:0] vals  [6] = '{4'd5, 4'hC, 4'd10, 4'hF, 4'd9, 4'd0};
        logic [3:0] exp_c [6] = '{4'd5, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0};
        bus1.en = 1; bus1.up = 1; bus1.load = 1;
        for (int i = 0; i < 6; i++) begin
            bus1.load_val = vals[i];
            tick();
            vectors++;
            if (bus1.count !== exp_c[i]) begin miscompares++; $display("FAIL load[%0d]: got %0d expected %0d", i, bus1.count, exp_c[i]); end
            vectors++;
            if (bus1.wrap !== 1'b0) begin miscompares++; $display("FAIL load_wrap[%0d]: got %b expected 0", i, bus1.wrap); end
            vectors++;
            if (bus1.tc !== (exp_c[i] == 4'd9)) begin miscompares++; $display("FAIL load_tc[%0d]: got %b expected %b", i, bus1.tc, exp_c[i] == 4'd9); end
        end
        bus1.load = 0; bus1.en = 0;
    endtask

    task automatic test_async_reset();
        bus1.load = 1; bus1.load_val = 4'd7;
        tick();
        bus1.load = 0; bus1.en = 0;
        tick();
        vectors++;
        if (bus1.count !== 4'd7) begin miscompares++; $display("FAIL hold: got %0d expected 7", bus1.count); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus1.count !== 4'd0) begin miscompares++; $display("FAIL async_count: got %0d expected 0", bus1.count); end
        vectors++;
        if (bus1.count_n !== 4'hF) begin miscompares++; $display("FAIL async_count_n: got %0h expected f", bus1.count_n); end
        vectors++;
        if (bus1.wrap !== 1'b0) begin miscompares++; $display("FAIL async_wrap: got %b expected 0", bus1.wrap); end
        #2 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
`ifndef JK_MOD_COUNTER_SAT_EN
        logic [1:0] exp_c [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        logic       exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        logic [1:0] exp_c [4] = '{2'd1, 2'd1, 2'd1, 2'd1};
        logic       exp_w [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif
        bus2.en = 1; bus2.up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus2.count !== exp_c[i]) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, bus2.count, exp_c[i]); end
            vectors++;
            if (bus2.wrap !== exp_w[i]) begin miscompares++; $display("FAIL b2b_wrap[%0d]: got %b expected %b", i, bus2.wrap, exp_w[i]); end
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus2.wrap !== 1'b0) begin miscompares++; $display("FAIL b2b_reset_wrap: got %b expected 0", bus2.wrap); end
        vectors++;
        if (bus2.count !== 2'd0) begin miscompares++; $display("FAIL b2b_reset_count: got %0d expected 0", bus2.count); end
        bus2.en = 0;
        #2 reset = 1'b1;
    endtask

    initial begin
        test_reset();
`ifndef JK_MOD_COUNTER_SAT_EN
        test_up_count();
`else
        test_saturate();
`endif
        test_down_count();
        test_load();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
